// File: rtl/map_inflate_window_max.sv
// Sliding KERNEL_SIZE x KERNEL_SIZE window maximum (grey-scale dilation) over KERNEL_SIZE row lanes.
// Optional MAP_BINARIZE_EN turns the window maximum into an occupied/free value using OCC_THRESH.
module map_inflate_window_max #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 64,
  parameter int CNT_WIDTH   = 7,
  parameter int OCC_THRESH  = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KERNEL_SIZE-1:0]            s_axis_tvalid,
  output logic [KERNEL_SIZE-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam logic [CNT_WIDTH-1:0] LAST_COL  = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] FILL_LAST = CNT_WIDTH'(KERNEL_SIZE - 2);

  if (KERNEL_SIZE < 2 || IMG_WIDTH < KERNEL_SIZE || (2 ** CNT_WIDTH) <= (IMG_WIDTH - 1) ||
      OCC_THRESH < 0 || OCC_THRESH >= (2 ** DATA_WIDTH)) begin : g_param_err
    $error("map_inflate_window_max: inconsistent parameters");
  end

  typedef enum logic {FILL, STREAM} state_t;

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    col_cnt;
  logic [DATA_WIDTH-1:0]   hist [KERNEL_SIZE];
  logic [DATA_WIDTH-1:0]   cmax;
  logic [DATA_WIDTH-1:0]   win_max;
  logic [DATA_WIDTH-1:0]   out_pix;
  logic                    pop;

  // A column is taken only when every lane offers data and the output register can accept.
  assign pop           = (&s_axis_tvalid) & (~m_axis_tvalid | m_axis_tready);
  assign s_axis_tready = {KERNEL_SIZE{pop}};

  always_comb begin
    cmax = s_axis_tdata[0 +: DATA_WIDTH];
    for (int k = 1; k < KERNEL_SIZE; k++) begin
      if (s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH] > cmax) begin
        cmax = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The newest column is still on the inputs, so only the KERNEL_SIZE-1 previous history entries join it.
  always_comb begin
    win_max = cmax;
    for (int k = 0; k < KERNEL_SIZE - 1; k++) begin
      if (hist[k] > win_max) begin
        win_max = hist[k];
      end
    end
  end

`ifdef MAP_BINARIZE_EN
  assign out_pix = (win_max >= DATA_WIDTH'(OCC_THRESH)) ? {DATA_WIDTH{1'b1}} : '0;
`else
  assign out_pix = win_max;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (pop && col_cnt == FILL_LAST) state_nxt = STREAM;
      STREAM:  if (pop && col_cnt == LAST_COL)  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Column history and counter advance only on a pop; a row wrap restarts the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        hist[k] <= '0;
      end
    end else if (pop) begin
      hist[0] <= cmax;
      for (int k = 1; k < KERNEL_SIZE; k++) begin
        hist[k] <= hist[k-1];
      end
      col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + CNT_WIDTH'(1);
    end
  end

  // Output register holds while stalled; a handshake with a same-cycle pop reloads it directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (pop && state == STREAM) begin
      m_axis_tdata  <= out_pix;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= (col_cnt == LAST_COL);
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_map_inflate_window_max.sv
// Directed bench for map_inflate_window_max with KERNEL_SIZE=3, DATA_WIDTH=8, IMG_WIDTH=8.
// Expected pixels pass through exp_px so the same vectors cover the MAP_BINARIZE_EN build.
module tb_map_inflate_window_max;

  localparam int KS = 3;
  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic [KS*DW-1:0] s_axis_tdata;
  logic [KS-1:0]   s_axis_tvalid;
  logic [KS-1:0]   s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;

  int checks = 0;
  int errors = 0;
  bit capture_en = 0;
  logic [8:0] cap_q[$];

  typedef struct {
    logic [7:0] l0, l1, l2;
    logic       exp_v;
    logic [7:0] exp_d;
    logic       exp_l;
  } vec_t;

  vec_t vecs[24];

  map_inflate_window_max #(
    .KERNEL_SIZE(KS), .DATA_WIDTH(DW), .IMG_WIDTH(8), .CNT_WIDTH(3), .OCC_THRESH(128)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshakes are recorded at the falling edge, where valid/ready equal their values at the next rising edge.
  always @(negedge clk) begin
    if (capture_en && m_axis_tvalid && m_axis_tready) cap_q.push_back({m_axis_tlast, m_axis_tdata});
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] exp_px(input logic [7:0] raw);
`ifdef MAP_BINARIZE_EN
    return (raw >= 8'd128) ? 8'hFF : 8'h00;
`else
    return raw;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                               input logic [2:0] v);
    s_axis_tdata  = {c, b, a};
    s_axis_tvalid = v;
  endtask

  task automatic pushColumn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    bit done;
    done = 1'b0;
    applyStimulus(a, b, c, 3'b111);
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = s_axis_tready[0];
      @(posedge clk);
    end
    #1;
    if (!done) checkOutput("pop_timeout", 0, 1);
  endtask

  task automatic midCycleReset(input string tag);
    applyStimulus(8'd0, 8'd0, 8'd0, 3'b000);
    #3;
    rst = 1'b1;
    #1;
    checkOutput({tag, "_tvalid"}, m_axis_tvalid, 0);
    checkOutput({tag, "_tdata"},  m_axis_tdata,  0);
    checkOutput({tag, "_tlast"},  m_axis_tlast,  0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] exp_q[6];
    logic [8:0] got;
    logic [2:0] skew_pats[4];

    // row 1: single obstacle; row 2: mixed lanes; row 3: threshold values 127/128/255
    vecs[0]  = '{8'd0,   8'd0,   8'd0,   1'b0, 8'd0,   1'b0};
    vecs[1]  = '{8'd0,   8'd0,   8'd0,   1'b0, 8'd0,   1'b0};
    vecs[2]  = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd0,   1'b0};
    vecs[3]  = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd0,   1'b0};
    vecs[4]  = '{8'd0,   8'd200, 8'd0,   1'b1, 8'd200, 1'b0};
    vecs[5]  = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd200, 1'b0};
    vecs[6]  = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd200, 1'b0};
    vecs[7]  = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd0,   1'b1};
    vecs[8]  = '{8'd10,  8'd20,  8'd5,   1'b0, 8'd0,   1'b0};
    vecs[9]  = '{8'd3,   8'd50,  8'd7,   1'b0, 8'd0,   1'b0};
    vecs[10] = '{8'd9,   8'd1,   8'd30,  1'b1, 8'd50,  1'b0};
    vecs[11] = '{8'd100, 8'd0,   8'd0,   1'b1, 8'd100, 1'b0};
    vecs[12] = '{8'd0,   8'd0,   8'd255, 1'b1, 8'd255, 1'b0};
    vecs[13] = '{8'd1,   8'd2,   8'd3,   1'b1, 8'd255, 1'b0};
    vecs[14] = '{8'd4,   8'd4,   8'd4,   1'b1, 8'd255, 1'b0};
    vecs[15] = '{8'd7,   8'd6,   8'd5,   1'b1, 8'd7,   1'b1};
    vecs[16] = '{8'd0,   8'd0,   8'd127, 1'b0, 8'd0,   1'b0};
    vecs[17] = '{8'd0,   8'd0,   8'd0,   1'b0, 8'd0,   1'b0};
    vecs[18] = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd127, 1'b0};
    vecs[19] = '{8'd128, 8'd0,   8'd0,   1'b1, 8'd128, 1'b0};
    vecs[20] = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd128, 1'b0};
    vecs[21] = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd128, 1'b0};
    vecs[22] = '{8'd0,   8'd255, 8'd0,   1'b1, 8'd255, 1'b0};
    vecs[23] = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd255, 1'b1};

    skew_pats[0] = 3'b001;
    skew_pats[1] = 3'b011;
    skew_pats[2] = 3'b101;
    skew_pats[3] = 3'b110;

    rst = 1'b1;
    m_axis_tready = 1'b1;
    applyStimulus(8'd0, 8'd0, 8'd0, 3'b000);
    #12;
    checkOutput("reset_tvalid", m_axis_tvalid, 0);
    checkOutput("reset_tdata",  m_axis_tdata,  0);
    checkOutput("reset_tlast",  m_axis_tlast,  0);
    checkOutput("reset_sready", s_axis_tready, 0);
    #11;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] three back-to-back rows from the vector table");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].l0, vecs[i].l1, vecs[i].l2, 3'b111);
      @(negedge clk);
      checkOutput($sformatf("v%0d_sready", i), s_axis_tready, 3'b111);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_tvalid", i), m_axis_tvalid, vecs[i].exp_v);
      if (vecs[i].exp_v) begin
        checkOutput($sformatf("v%0d_tdata", i), m_axis_tdata, exp_px(vecs[i].exp_d));
        checkOutput($sformatf("v%0d_tlast", i), m_axis_tlast, vecs[i].exp_l);
      end
    end

    $display("[TB] asynchronous reset with a valid output pending");
    midCycleReset("async_rst");
    for (int p = 0; p < 4; p++) begin
      applyStimulus(8'd1, 8'd2, 8'd3, skew_pats[p]);
      #1;
      checkOutput($sformatf("partial_valid_%0d_sready", p), s_axis_tready, 0);
    end
    applyStimulus(8'd1, 8'd2, 8'd3, 3'b111);
    #1;
    checkOutput("all_valid_sready", s_axis_tready, 3'b111);
    applyStimulus(8'd0, 8'd0, 8'd0, 3'b000);
    @(posedge clk);
    #1;

    $display("[TB] reset after five columns of a row");
    for (int c = 0; c < 5; c++) pushColumn(8'd250, 8'd250, 8'd250);
    checkOutput("pre_midrow_tvalid", m_axis_tvalid, 1);
    midCycleReset("midrow_rst");

    $display("[TB] lane skew: only lane 0 valid");
    applyStimulus(8'd77, 8'd0, 8'd0, 3'b001);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checkOutput($sformatf("skew_%0d_sready", n), s_axis_tready, 0);
      checkOutput($sformatf("skew_%0d_tvalid", n), m_axis_tvalid, 0);
      @(posedge clk);
    end
    #1;

    $display("[TB] full row with backpressure");
    cap_q.delete();
    capture_en = 1'b1;
    pushColumn(8'd5, 8'd0, 8'd0);
    pushColumn(8'd0, 8'd9, 8'd0);
    pushColumn(8'd0, 8'd0, 8'd2);
    pushColumn(8'd7, 8'd1, 8'd0);
    m_axis_tready = 1'b0;
    applyStimulus(8'd1, 8'd1, 8'd1, 3'b111);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_%0d_tvalid", n), m_axis_tvalid, 1);
      checkOutput($sformatf("stall_%0d_tdata", n),  m_axis_tdata,  exp_px(8'd9));
      checkOutput($sformatf("stall_%0d_tlast", n),  m_axis_tlast,  0);
      checkOutput($sformatf("stall_%0d_sready", n), s_axis_tready, 0);
      @(posedge clk);
      #1;
    end
    m_axis_tready = 1'b1;
    pushColumn(8'd1, 8'd1, 8'd1);
    pushColumn(8'd0, 8'd1, 8'd0);
    pushColumn(8'd8, 8'd0, 8'd0);
    pushColumn(8'd3, 8'd3, 8'd3);
    applyStimulus(8'd0, 8'd0, 8'd0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    capture_en = 1'b0;

    exp_q[0] = {1'b0, exp_px(8'd9)};
    exp_q[1] = {1'b0, exp_px(8'd9)};
    exp_q[2] = {1'b0, exp_px(8'd7)};
    exp_q[3] = {1'b0, exp_px(8'd7)};
    exp_q[4] = {1'b0, exp_px(8'd8)};
    exp_q[5] = {1'b1, exp_px(8'd8)};
    checkOutput("row4_output_count", cap_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 9'h1FF;
      checkOutput($sformatf("row4_out%0d_last_data", i), got, exp_q[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
